// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush controller for the five-stage core. Merges stall
// requests from the IF bus port, ID (load-use), EX (multi-cycle) and the MEM
// bus port into the 6-bit stall vector. It turns an exception or ERET reported
// by MEM into a one-cycle flush with a redirect PC. A flush waits while an
// AXI-Lite transaction is outstanding, so a bus handshake is never abandoned.
//
// Optional feature macro: PIPELINE_CTRL_PERF_EN
//   When defined, adds the stall_cycles output (32-bit wrapping count of
//   cycles with stall[0]=1).
//
// Parameters
//   EXC_VECTOR    redirect PC for all non-ERET exceptions
//   ERET_CODE     excepttype value that denotes ERET
//   STALL_TIMEOUT consecutive stalled cycles that set stall_timeout
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   stallreq_from_if  instruction bus transaction outstanding
//   stallreq_from_id  load-use hazard
//   stallreq_from_ex  multi-cycle EX operation busy
//   stallreq_from_mem data bus transaction outstanding
//   excepttype        exception code from MEM (0 = none)
//   cp0_epc           EPC used as the ERET target
//   stall[5:0]        hold: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   flush             one-cycle clear of all pipeline registers
//   new_pc            redirect target, valid while flush=1, else 0
//   stall_timeout     sticky watchdog flag, cleared only by rst
//   stall_cycles      stalled-cycle counter (PIPELINE_CTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE     = 32'h0000000E,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    PEND_FLUSH = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pend_pc_reg, pend_pc_next;
  logic [15:0] wd_count_reg, wd_count_next;
  logic        timeout_reg, timeout_next;

  logic [5:0]  stall_int;
  logic        flush_int;
  logic [31:0] new_pc_int;

  // Either bus port has a handshake in flight; a flush must wait for both.
  logic        bus_busy;
  logic        exc_present;
  logic [31:0] exc_target;

  assign bus_busy    = stallreq_from_if | stallreq_from_mem;
  assign exc_present = (excepttype != 32'd0);
  assign exc_target  = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pend_pc_reg  <= 32'd0;
      wd_count_reg <= 16'd0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pend_pc_reg  <= pend_pc_next;
      wd_count_reg <= wd_count_next;
      timeout_reg  <= timeout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    pend_pc_next = pend_pc_reg;
    stall_int    = 6'b000000;
    flush_int    = 1'b0;
    new_pc_int   = 32'd0;

    case (state_reg)
      IDLE: begin
        if (exc_present) begin
          if (bus_busy) begin
            // Freeze everything and remember where to go once the bus drains.
            stall_int    = 6'b111111;
            pend_pc_next = exc_target;
            state_next   = PEND_FLUSH;
          end else begin
            flush_int  = 1'b1;
            new_pc_int = exc_target;
          end
        end else if (stallreq_from_mem) begin
          stall_int = 6'b011111;
        end else if (stallreq_from_ex) begin
          stall_int = 6'b001111;
        end else if (stallreq_from_id) begin
          stall_int = 6'b000111;
        end else if (stallreq_from_if) begin
          stall_int = 6'b000011;
        end
      end

      PEND_FLUSH: begin
        // New exception codes are ignored here: the first one owns the flush.
        if (bus_busy) begin
          stall_int = 6'b111111;
        end else begin
          flush_int    = 1'b1;
          new_pc_int   = pend_pc_reg;
          pend_pc_next = 32'd0;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are held quiet for the whole reset pulse, not just after the edge.
  assign stall  = rst ? 6'b000000 : stall_int;
  assign flush  = rst ? 1'b0      : flush_int;
  assign new_pc = rst ? 32'd0     : new_pc_int;

  // ---------------------------------------------------------------------------
  // Watchdog: counts consecutive PC-stall cycles, saturating. The flag is set
  // on the same edge the counter lands on STALL_TIMEOUT, so it becomes visible
  // right after the STALL_TIMEOUT-th stalled cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    wd_count_next = 16'd0;
    timeout_next  = timeout_reg;
    if (stall_int[0]) begin
      if (wd_count_reg == 16'hFFFF) begin
        wd_count_next = wd_count_reg;
      end else begin
        wd_count_next = wd_count_reg + 16'd1;
      end
      if (wd_count_next == STALL_TIMEOUT) begin
        timeout_next = 1'b1;
      end
    end
  end

  assign stall_timeout = timeout_reg;

`ifdef PIPELINE_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counter: total stalled cycles, wraps naturally at 2^32.
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg <= 32'd0;
    end else if (stall_int[0]) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Self-checking bench for pipeline_ctrl (STALL_TIMEOUT overridden to 16).
// A behavioural model tracks "is a flush owed, and to where", the run length
// of stalled cycles and the sticky timeout flag; a compare process checks the
// DUT against it every falling edge. Directed sequences pin the model with
// literal expectations, then a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam logic [31:0] EXC_VEC  = 32'hBFC00380;
  localparam logic [31:0] ERET     = 32'h0000000E;
  localparam int          WD_LIMIT = 16;

  logic        clk;
  logic        rst;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  pipeline_ctrl #(
    .EXC_VECTOR   (EXC_VEC),
    .ERET_CODE    (ERET),
    .STALL_TIMEOUT(16'd16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (stallreq_from_if),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .stallreq_from_mem(stallreq_from_mem),
    .excepttype       (excepttype),
    .cp0_epc          (cp0_epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout    (stall_timeout)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit          m_owed;      // a flush is owed but waits for the bus
  logic [31:0] m_owed_pc;
  int          m_run;       // consecutive stalled cycles, saturating at 65535
  bit          m_timeout;
  logic [31:0] m_perf;

  initial begin
    m_owed    = 1'b0;
    m_owed_pc = 32'd0;
    m_run     = 0;
    m_timeout = 1'b0;
    m_perf    = 32'd0;
  end

  function automatic void model_out(output logic [5:0] s, output logic f, output logic [31:0] pc);
    bit busy;
    busy = stallreq_from_if || stallreq_from_mem;
    s = 6'd0; f = 1'b0; pc = 32'd0;
    if (rst) return;
    if (m_owed) begin
      if (busy) s = 6'h3F;
      else begin f = 1'b1; pc = m_owed_pc; end
    end else if (excepttype != 0) begin
      if (busy) s = 6'h3F;
      else begin
        f  = 1'b1;
        pc = (excepttype == ERET) ? cp0_epc : EXC_VEC;
      end
    end else if (stallreq_from_mem) s = 6'b011111;
    else if (stallreq_from_ex)      s = 6'b001111;
    else if (stallreq_from_id)      s = 6'b000111;
    else if (stallreq_from_if)      s = 6'b000011;
  endfunction

  always @(posedge clk) begin
    logic [5:0]  s;
    logic        f;
    logic [31:0] pc;
    bit          busy;
    if (rst) begin
      m_owed = 1'b0; m_owed_pc = 32'd0; m_run = 0; m_timeout = 1'b0; m_perf = 32'd0;
    end else begin
      model_out(s, f, pc);
      busy = stallreq_from_if || stallreq_from_mem;
      if (s[0]) begin
        if (m_run < 65535) m_run = m_run + 1;
        if (m_run == WD_LIMIT) m_timeout = 1'b1;
        m_perf = m_perf + 32'd1;
      end else begin
        m_run = 0;
      end
      if (m_owed) begin
        if (!busy) m_owed = 1'b0;
      end else if (excepttype != 0 && busy) begin
        m_owed    = 1'b1;
        m_owed_pc = (excepttype == ERET) ? cp0_epc : EXC_VEC;
      end
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [5:0]  s;
    logic        f;
    logic [31:0] pc;
    if (chk_en) begin
      model_out(s, f, pc);
      chk("model_stall",   {26'd0, stall}, {26'd0, s});
      chk("model_flush",   {31'd0, flush}, {31'd0, f});
      chk("model_new_pc",  new_pc, pc);
      chk("model_timeout", {31'd0, stall_timeout}, {31'd0, (rst ? 1'b0 : m_timeout)});
`ifdef PIPELINE_CTRL_PERF_EN
      chk("model_perf",    stall_cycles, rst ? 32'd0 : m_perf);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input bit r, input bit i_if, input bit i_id, input bit i_ex,
                       input bit i_mem, input logic [31:0] exc, input logic [31:0] epc);
    @(posedge clk);
    #1;
    rst               = r;
    stallreq_from_if  = i_if;
    stallreq_from_id  = i_id;
    stallreq_from_ex  = i_ex;
    stallreq_from_mem = i_mem;
    excepttype        = exc;
    cp0_epc           = epc;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] s, input logic f,
                            input logic [31:0] pc);
    @(negedge clk);
    chk({tag, "_stall"},  {26'd0, stall}, {26'd0, s});
    chk({tag, "_flush"},  {31'd0, flush}, {31'd0, f});
    chk({tag, "_new_pc"}, new_pc, pc);
  endtask

  initial begin
    rst               = 1'b1;
    stallreq_from_if  = 1'b0;
    stallreq_from_id  = 1'b0;
    stallreq_from_ex  = 1'b0;
    stallreq_from_mem = 1'b1;   // outputs must stay quiet under reset anyway
    excepttype        = 32'd0;
    cp0_epc           = 32'd0;
    chk_en            = 1'b1;

    // Reset state
    expect_out("reset", 6'd0, 1'b0, 32'd0);
    chk("reset_timeout", {31'd0, stall_timeout}, 32'd0);

    // Load-use stall for 3 cycles, then release
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 32'd0, 32'd0);
      expect_out("id_stall", 6'b000111, 1'b0, 32'd0);
    end
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    expect_out("id_release", 6'b000000, 1'b0, 32'd0);

    // Priority: ex+if, then add mem
    drive(0, 1, 0, 1, 0, 32'd0, 32'd0);
    expect_out("ex_if", 6'b001111, 1'b0, 32'd0);
    drive(0, 1, 0, 1, 1, 32'd0, 32'd0);
    expect_out("mem_ex_if", 6'b011111, 1'b0, 32'd0);
    drive(0, 1, 0, 0, 0, 32'd0, 32'd0);
    expect_out("if_only", 6'b000011, 1'b0, 32'd0);

    // Immediate exception flush
    drive(0, 0, 0, 0, 0, 32'h8, 32'h1111_2222);
    expect_out("exc_now", 6'd0, 1'b1, 32'hBFC00380);
    drive(0, 0, 0, 0, 0, 32'd0, 32'h1111_2222);
    expect_out("exc_after", 6'd0, 1'b0, 32'd0);

    // ERET deferred behind a 4-cycle data bus transaction
    drive(0, 0, 0, 0, 1, 32'hE, 32'h80001234);
    expect_out("eret_hold1", 6'h3F, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 1, 32'h8, 32'h0);   // later codes must be ignored
      expect_out("eret_hold", 6'h3F, 1'b0, 32'd0);
    end
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    expect_out("eret_flush", 6'd0, 1'b1, 32'h80001234);
    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    expect_out("eret_done", 6'd0, 1'b0, 32'd0);

    // Watchdog: 16 consecutive stalled cycles set the sticky flag
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 1, 0, 32'd0, 32'd0);
      @(negedge clk);
      chk($sformatf("wd_cycle%0d", i), {31'd0, stall_timeout}, {31'd0, (i >= 17)});
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
      @(negedge clk);
      chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);
    end
    drive(1, 0, 0, 0, 0, 32'd0, 32'd0);
    @(negedge clk);
    chk("wd_rst_clear", {31'd0, stall_timeout}, 32'd0);

    // Reset while a flush is pending drops it
    drive(0, 1, 0, 0, 0, 32'h8, 32'd0);
    expect_out("pend_enter", 6'h3F, 1'b0, 32'd0);
    drive(1, 0, 0, 0, 0, 32'd0, 32'd0);
    expect_out("pend_rst", 6'd0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
      expect_out("pend_dropped", 6'd0, 1'b0, 32'd0);
    end

    // Randomized phase, checked by the compare process
    for (int k = 0; k < 3000; k++) begin
      bit          r, b_if, b_id, b_ex, b_mem;
      logic [31:0] exc;
      int          sel;
      r     = ($urandom_range(0, 299) == 0);
      b_if  = ($urandom_range(0, 99) < 30);
      b_id  = ($urandom_range(0, 99) < 20);
      b_ex  = ($urandom_range(0, 99) < 20);
      b_mem = ($urandom_range(0, 99) < 25) || ((k % 400) < 25);
      sel   = $urandom_range(0, 99);
      if (sel < 8)       exc = ERET;
      else if (sel < 16) exc = 32'h8;
      else if (sel < 20) exc = $urandom() | 32'h1;
      else               exc = 32'd0;
      drive(r, b_if, b_id, b_ex, b_mem, exc, $urandom());
    end

    drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage core. It merges stall requests from the instruction-fetch bus port, ID (load-use), EX (multi-cycle ops) and the data bus port into the 6-bit `stall` vector consumed by the PC register and every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB). It converts exceptions and ERET from MEM into a one-cycle `flush` with a redirect PC. A flush is deferred while an AXI-Lite transaction is still outstanding, so a bus handshake is never abandoned.

## Interface
- `EXC_VECTOR`, 32'hBFC00380: redirect PC for all non-ERET exceptions.
- `ERET_CODE`, 32'h0000000E: `excepttype` value that denotes ERET.
- `STALL_TIMEOUT`, 16'd1024: consecutive stalled cycles that set `stall_timeout`.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stallreq_from_if` in 1: instruction bus transaction outstanding.
- `stallreq_from_id` in 1: load-use hazard.
- `stallreq_from_ex` in 1: multi-cycle EX operation busy.
- `stallreq_from_mem` in 1: data bus transaction outstanding.
- `excepttype` in 32: exception code from MEM; 0 = none.
- `cp0_epc` in 32: EPC for ERET.
- `stall` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- `flush` out 1: clears all pipeline registers and loads `new_pc`.
- `new_pc` out 32: redirect target, valid while `flush`=1.
- `stall_timeout` out 1: sticky watchdog flag.
- `stall_cycles` out 32: only with `PIPELINE_CTRL_PERF_EN`.

## Operation
- Two states: IDLE and PEND_FLUSH.
- IDLE, `excepttype`=0: `stall` is combinational, first match wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
  - `flush`=0.
- IDLE, `excepttype`≠0, both bus requests low:
  - `flush`=1 and `stall`=0 in the same cycle.
  - `new_pc` = `cp0_epc` if `excepttype`==`ERET_CODE`, else `EXC_VECTOR`.
  - Stay in IDLE.
- IDLE, `excepttype`≠0, either bus request high:
  - `stall`=6'b111111, `flush`=0.
  - Latch the redirect target into `pend_pc`; go to PEND_FLUSH.
- PEND_FLUSH:
  - `stall`=6'b111111 while either bus request is high.
  - In the first cycle both are low: `flush`=1, `stall`=0, `new_pc`=`pend_pc`; go to IDLE.
  - `excepttype` changes are ignored.
- `new_pc`=0 whenever `flush`=0.
- Watchdog:
  - 16-bit counter increments each cycle `stall[0]`=1, saturating at all-ones; clears when `stall[0]`=0.
  - `stall_timeout` sets when the counter equals `STALL_TIMEOUT`; cleared only by `rst`.

## Timing
- `stall`, `flush` and `new_pc` are combinational from inputs and state: zero-cycle latency.
- Reset values:
  - state = IDLE, `pend_pc`=0, watchdog counter = 0, `stall_timeout`=0, `stall_cycles`=0.
  - While `rst` is high: outputs `stall`=0, `flush`=0, `new_pc`=0.
- Deferred flush occurs exactly one cycle after the last cycle in which a bus request was high.
- Bus request and exception in the same cycle: the exception wins; the flush is deferred.
- `rst` asserted in PEND_FLUSH: return to IDLE immediately; the pending flush is dropped.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined: adds output `stall_cycles`, a 32-bit counter incremented every cycle `stall[0]`=1. It wraps at 2^32 and resets to 0.
- Undefined: port and counter absent; all other behaviour is identical.

## Test plan
- Only `stallreq_from_id`=1 for 3 cycles → `stall`=6'b000111 for those 3 cycles, then 6'b000000; `flush`=0 throughout.
- `stallreq_from_ex`=1 and `stallreq_from_if`=1 together → `stall`=6'b001111; add `stallreq_from_mem`=1 → 6'b011111.
- `excepttype`=32'h8, no bus requests → same cycle `flush`=1, `stall`=0, `new_pc`=32'hBFC00380.
- `excepttype`=32'hE, `cp0_epc`=32'h80001234, `stallreq_from_mem` high for 4 cycles:
  - `stall`=6'b111111 for 4 cycles.
  - 5th cycle: `flush`=1, `new_pc`=32'h80001234.
- `stallreq_from_ex` held high with `STALL_TIMEOUT`=16:
  - `stall_timeout` rises on the 16th stalled cycle and stays high after the request drops.
  - It clears only on `rst`.
- `rst` pulsed while in PEND_FLUSH → no `flush` afterward; `stall`=0 and `new_pc`=0 once inputs are idle.
